div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin arbiter and sequencer that shares one iterative 32-bit RV32M divider among `NUM_REQ` requesters (issue ports or harts). It accepts DIV/DIVU/REM/REMU requests, drives the divider's start/sign/operand inputs, and detects result validity from the divider's ready-style valid output. It returns the selected quotient or remainder with the requester's tag over a valid/ready response channel. It sits between the execute-stage M-unit issue logic and the `divider` instance.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `TAG_W`, 4: width of the opaque tag returned with each response.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  global freeze; the FSM and all registers hold.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  one-hot accept pulse to the granted requester.
- `req_op_i`  in  2*NUM_REQ  per-requester op: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
- `req_a_i`, `req_b_i`  in  32*NUM_REQ  per-requester dividend and divisor.
- `req_tag_i`  in  TAG_W*NUM_REQ  per-requester tag.
- `rsp_valid_o`  out  NUM_REQ  one-hot response valid to the owning requester.
- `rsp_ready_i`  in  NUM_REQ  per-requester response ready.
- `rsp_data_o`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- `rsp_tag_o`  out  TAG_W  tag of the completed request.
- `div_start_o`, `div_sign_o`, `div_stall_o`  out  1  divider controls.
- `div_dividend_o`, `div_divider_o`  out  32  divider operands.
- `div_quotient_i`, `div_remainder_i`  in  32  divider results.
- `div_valid_i`  in  1  divider valid; high when idle and when done.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any `req_valid_i` is high, grant round-robin starting at the index after the last grant. Pulse `req_ready_o[g]` for that cycle. Latch op, a, b and tag into internal registers. Go to LAUNCH.
- LAUNCH: `div_start_o`=1. The divider is idle, so its valid output is ignored. Go to WAIT.
- WAIT: `div_start_o`=1. When `div_valid_i`=1, capture `div_quotient_i` or `div_remainder_i` according to op. Drop start and go to RESP.
- RESP: `rsp_valid_o[g]`=1 with data and tag held stable. On `rsp_ready_i[g]`=1, go to IDLE. No new grant is made in this cycle.
- `div_sign_o` = op is DIV or REM. Operands and sign are driven from the latched registers and stay constant from LAUNCH through capture.
- `div_stall_o` = `stall_i`. While stalled, the state, the round-robin pointer and all outputs hold. `req_ready_o` is forced to 0.
- The divider's result conventions (divide-by-zero gives −1 / dividend; signed overflow gives 0x80000000 / 0) pass through unchanged.
- Reset: state IDLE, pointer 0, every output 0.

## Timing
- Request accepted in cycle T. LAUNCH at T+1. `div_valid_i` rises at T+2+bits, where bits = 3..32 from the dividend magnitude (3 for |a|≤7, for divide-by-zero and for signed overflow). `rsp_valid_o` is high at T+3+bits.
- Throughput: one request in flight. The next grant is possible in the cycle after the response handshake.
- A requester that stays valid with no accept keeps its operands stable. The arbiter does not sample them until the grant cycle.
- Asynchronous reset mid-operation aborts the request with no response. The divider is reset by the same reset_i.

## Configuration
- `DIV_ARB_REUSE_EN`: compiled in, a result cache holds {sign, a, b, Q, R, valid} from the last divider completion.
  - An IDLE grant whose sign/a/b match a valid entry skips the divider and enters RESP at T+1. This covers fused DIV+REM pairs.
  - The entry is cleared on reset.
- Without the macro: no cache, and every request runs through the divider.

## Test plan
- Requester 0 sends DIVU 100/7, tag 3, accepted at T. Required: `rsp_valid_o`=01 at T+10, data 14, tag 3.
- Requester 1 sends REM −7/2. Required: data 0xFFFFFFFF (−1); DIV of the same operands returns 0xFFFFFFFD (−3).
- DIV 0x80000000/−1 → data 0x80000000. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Response at T+6 in each case.
- Both requesters hold valid continuously. Required: grants alternate 0,1,0,1. `rsp_ready_i` held low for 5 cycles holds data, tag and state.
- Assert `stall_i` for 4 cycles in WAIT. Required: response delayed by exactly 4 cycles with the correct value. Reset asserted mid-WAIT: all outputs are 0 immediately and no response follows.
- With `DIV_ARB_REUSE_EN`: DIV 1000/3 then REM 1000/3. Required: the second request responds at T+1 with data 1 and `div_start_o` stays 0.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one iterative RV32M divider among NUM_REQ requesters.
// Define DIV_ARB_REUSE_EN to add a one-entry result cache that answers repeated operands without the divider.
module div_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     stall_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [2*NUM_REQ-1:0]     req_op_i,
    input  logic [32*NUM_REQ-1:0]    req_a_i,
    input  logic [32*NUM_REQ-1:0]    req_b_i,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [31:0]              rsp_data_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic                     div_start_o,
    output logic                     div_sign_o,
    output logic                     div_stall_o,
    output logic [31:0]              div_dividend_o,
    output logic [31:0]              div_divider_o,
    input  logic [31:0]              div_quotient_i,
    input  logic [31:0]              div_remainder_i,
    input  logic                     div_valid_i
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]         r_state, w_next;
    logic [IDX_W-1:0]   r_ptr, r_gnt, w_gnt, w_cand, w_owner;
    logic               w_found, w_grant, w_capture, w_hit;
    logic               r_sign, r_rem, r_start;
    logic [31:0]        r_a, r_b, r_data, w_hit_data;
    logic [TAG_W-1:0]   r_tag;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic [1:0]         w_op_arr  [NUM_REQ];
    logic [31:0]        w_a_arr   [NUM_REQ];
    logic [31:0]        w_b_arr   [NUM_REQ];
    logic [TAG_W-1:0]   w_tag_arr [NUM_REQ];
    logic [1:0]         w_sel_op;
    logic [31:0]        w_sel_a, w_sel_b;
    logic [TAG_W-1:0]   w_sel_tag;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_op_arr[i]  = req_op_i[2*i +: 2];
            w_a_arr[i]   = req_a_i[32*i +: 32];
            w_b_arr[i]   = req_b_i[32*i +: 32];
            w_tag_arr[i] = req_tag_i[TAG_W*i +: TAG_W];
        end
    end

    // Round-robin scan starting at r_ptr, the index after the last grant
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_sel_op  = w_op_arr[w_gnt];
    assign w_sel_a   = w_a_arr[w_gnt];
    assign w_sel_b   = w_b_arr[w_gnt];
    assign w_sel_tag = w_tag_arr[w_gnt];

`ifdef DIV_ARB_REUSE_EN
    logic        r_c_valid, r_c_sign;
    logic [31:0] r_c_a, r_c_b, r_c_q, r_c_r;

    assign w_hit = r_c_valid && (r_c_sign == ~w_sel_op[0]) &&
                   (r_c_a == w_sel_a) && (r_c_b == w_sel_b);
    assign w_hit_data = w_sel_op[1] ? r_c_r : r_c_q;

    // Remember the most recent divider completion, quotient and remainder both
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_c_valid <= 1'b0;
            r_c_sign  <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_q     <= '0;
            r_c_r     <= '0;
        end else if (!stall_i && w_capture) begin
            r_c_valid <= 1'b1;
            r_c_sign  <= r_sign;
            r_c_a     <= r_a;
            r_c_b     <= r_b;
            r_c_q     <= div_quotient_i;
            r_c_r     <= div_remainder_i;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant = 1'b1;
                    w_next  = w_hit ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (div_valid_i) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[r_gnt]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_owner     = w_grant ? w_gnt : r_gnt;
    assign req_ready_o = (w_grant && !stall_i && !reset_i) ? (NUM_REQ'(1) << w_gnt) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_sign      <= 1'b0;
            r_rem       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= '0;
        end else if (!stall_i) begin
            r_state     <= w_next;
            r_start     <= (w_next == S_LAUNCH) || (w_next == S_WAIT);
            r_rsp_valid <= (w_next == S_RESP) ? (NUM_REQ'(1) << w_owner) : '0;
            if (w_grant) begin
                r_gnt  <= w_gnt;
                r_ptr  <= IDX_W'((32'(w_gnt) + 32'd1) % NUM_REQ);
                r_sign <= ~w_sel_op[0];
                r_rem  <= w_sel_op[1];
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_tag  <= w_sel_tag;
                if (w_hit) r_data <= w_hit_data;
            end
            if (w_capture) r_data <= r_rem ? div_remainder_i : div_quotient_i;
        end
    end

    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_data_o     = r_data;
    assign rsp_tag_o      = r_tag;
    assign div_start_o    = r_start;
    assign div_sign_o     = r_sign;
    assign div_stall_o    = stall_i;
    assign div_dividend_o = r_a;
    assign div_divider_o  = r_b;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed checks of div_arbiter against a transaction-level model,
// with a cycle-level stand-in for the iterative divider.
module tb_div_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned TW = 4;

    logic            clk_i = 1'b0;
    logic            reset_i, stall_i;
    logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [2*N-1:0]  req_op_i;
    logic [32*N-1:0] req_a_i, req_b_i;
    logic [TW*N-1:0] req_tag_i;
    logic [31:0]     rsp_data_o, div_dividend_o, div_divider_o, div_quotient_i, div_remainder_i;
    logic [TW-1:0]   rsp_tag_o;
    logic            div_start_o, div_sign_o, div_stall_o, div_valid_i;

    logic [1:0]      f_op  [N];
    logic [31:0]     f_a   [N];
    logic [31:0]     f_b   [N];
    logic [TW-1:0]   f_tag [N];

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int start_cnt = 0;
    int prio = 0;
    bit          c_valid = 1'b0;
    logic        c_sign;
    logic [31:0] c_a, c_b;

    div_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
        .div_start_o(div_start_o), .div_sign_o(div_sign_o), .div_stall_o(div_stall_o),
        .div_dividend_o(div_dividend_o), .div_divider_o(div_divider_o),
        .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
        .div_valid_i(div_valid_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) if (div_start_o) start_cnt <= start_cnt + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op_i[2*i +: 2]    = f_op[i];
            req_a_i[32*i +: 32]   = f_a[i];
            req_b_i[32*i +: 32]   = f_b[i];
            req_tag_i[TW*i +: TW] = f_tag[i];
        end
    end

    // RV32M result, {quotient, remainder}
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        if (sgn) begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sq, sr};
        end
        return {a / b, a % b};
    endfunction

    // Divider iteration count: bit length of |dividend|, at least 3
    function automatic int ref_bits(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int n;
        if (b == 32'd0) return 3;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        mag = (sgn && a[31]) ? -a : a;
        n = 0;
        while (mag != 32'd0) begin
            n++;
            mag = mag >> 1;
        end
        return (n < 3) ? 3 : n;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (prio + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Divider stand-in: valid when idle or done, busy for ref_bits cycles after start
    int          dv_state = 0;
    int          dv_cnt = 0;
    logic [31:0] dv_q, dv_r;
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dv_state <= 0;
            dv_cnt   <= 0;
            dv_q     <= '0;
            dv_r     <= '0;
        end else if (!div_stall_o) begin
            case (dv_state)
                0: if (div_start_o) begin
                    dv_state     <= 1;
                    dv_cnt       <= ref_bits(div_sign_o, div_dividend_o, div_divider_o);
                    {dv_q, dv_r} <= ref_div(div_sign_o, div_dividend_o, div_divider_o);
                end
                1: if (dv_cnt <= 1) dv_state <= 2; else dv_cnt <= dv_cnt - 1;
                default: if (!div_start_o) dv_state <= 0;
            endcase
        end
    end
    assign div_valid_i     = (dv_state != 1);
    assign div_quotient_i  = (dv_state == 2) ? dv_q : 32'hDEAD_BEEF;
    assign div_remainder_i = (dv_state == 2) ? dv_r : 32'hBAD0_F00D;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One complete transaction for whichever requester the model expects to win
    task automatic serve(input int stall_n, input int hold_n, input bit drop);
        int g, lat, bits, t0, s0, k;
        logic sgn;
        logic [63:0] qr;
        logic [31:0] exp_data;
        logic [TW-1:0] exp_tag;
        logic [N-1:0] exp_v;
        bit hit, ok;
        #1;
        g = model_pick(req_valid_i);
        if (g < 0) begin
            chk("no_request", 128'(0), 128'(1));
            return;
        end
        for (k = 0; k < 20 && req_ready_o == '0; k++) begin @(negedge clk_i); #1; end
        exp_v = '0;
        exp_v[g] = 1'b1;
        chk("grant", 128'(req_ready_o), 128'(exp_v));
        if (req_ready_o == '0) return;
        t0 = cyc;
        s0 = start_cnt;
        sgn = ~f_op[g][0];
        qr = ref_div(sgn, f_a[g], f_b[g]);
        exp_data = f_op[g][1] ? qr[31:0] : qr[63:32];
        exp_tag = f_tag[g];
        bits = ref_bits(sgn, f_a[g], f_b[g]);
        hit = 1'b0;
`ifdef DIV_ARB_REUSE_EN
        hit = c_valid && (c_sign == sgn) && (c_a == f_a[g]) && (c_b == f_b[g]);
        if (!hit) begin
            c_valid = 1'b1;
            c_sign = sgn;
            c_a = f_a[g];
            c_b = f_b[g];
        end
`endif
        lat = hit ? 1 : bits + 3 + stall_n;
        prio = (g + 1) % N;
        @(negedge clk_i);
        if (drop) req_valid_i[g] = 1'b0;
        if (stall_n > 0 && !hit) begin
            @(negedge clk_i);
            @(negedge clk_i);
            stall_i = 1'b1;
            repeat (stall_n) @(negedge clk_i);
            stall_i = 1'b0;
        end
        #1;
        for (k = 0; k < 200 && rsp_valid_o == '0; k++) begin @(negedge clk_i); #1; end
        chk("rsp_valid", 128'(rsp_valid_o), 128'(exp_v));
        chk("rsp_latency", 128'(cyc - t0), 128'(lat));
        chk("rsp_data", 128'(rsp_data_o), 128'(exp_data));
        chk("rsp_tag", 128'(rsp_tag_o), 128'(exp_tag));
        chk("start_cycles", 128'(start_cnt - s0), 128'(hit ? 0 : bits + 2 + stall_n));
        ok = 1'b1;
        repeat (hold_n) begin
            @(negedge clk_i);
            #1;
            if (rsp_valid_o !== exp_v || rsp_data_o !== exp_data || rsp_tag_o !== exp_tag ||
                req_ready_o !== '0 || div_start_o !== 1'b0) ok = 1'b0;
        end
        chk("rsp_hold", 128'(ok), 128'(1));
        rsp_ready_i[g] = 1'b1;
        #1;
        chk("no_grant_in_handshake", 128'(req_ready_o), 128'(0));
        @(negedge clk_i);
        rsp_ready_i[g] = 1'b0;
        #1;
        chk("rsp_released", 128'(rsp_valid_o), 128'(0));
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TW-1:0] tag);
        f_op[r] = op;
        f_a[r] = a;
        f_b[r] = b;
        f_tag[r] = tag;
        req_valid_i[r] = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 128'({req_ready_o, rsp_valid_o, rsp_tag_o, div_start_o, div_sign_o, div_stall_o}), 128'(0));
        chk({tag, "_data"}, 128'({rsp_data_o, div_dividend_o, div_divider_o}), 128'(0));
    endtask

    initial begin
        bit ok;
        int k;
        logic [31:0] last_a, last_b;
        reset_i = 1'b1;
        stall_i = 1'b0;
        rsp_ready_i = '0;
        req_valid_i = '1;
        for (int i = 0; i < N; i++) begin
            f_op[i] = 2'd0; f_a[i] = 32'd9; f_b[i] = 32'd2; f_tag[i] = '0;
        end
        repeat (3) @(negedge clk_i);
        #1;
        chk_all_zero("reset_state");
        req_valid_i = '0;
        @(negedge clk_i);
        reset_i = 1'b0;

        // DIVU 100/7 from requester 0: 7 iterations, response ten cycles after accept
        set_req(0, 2'd1, 32'd100, 32'd7, 4'd3);
        serve(0, 0, 1);
        // Signed REM/DIV of -7/2 from requester 1
        set_req(1, 2'd2, 32'hFFFF_FFF9, 32'd2, 4'd5);
        serve(0, 1, 1);
        set_req(1, 2'd0, 32'hFFFF_FFF9, 32'd2, 4'd6);
        serve(0, 0, 1);
        // Overflow and divide-by-zero corner cases
        set_req(0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1);
        serve(0, 0, 1);
        set_req(1, 2'd1, 32'd5, 32'd0, 4'd2);
        serve(0, 0, 1);
        set_req(0, 2'd3, 32'd5, 32'd0, 4'd4);
        serve(0, 0, 1);

        // Both requesters valid throughout: grants alternate, one response held for 5 cycles
        set_req(0, 2'd1, 32'd1000, 32'd10, 4'd7);
        set_req(1, 2'd0, 32'hFFFF_FFCE, 32'd7, 4'd8);
        for (int t = 0; t < 4; t++) serve(0, (t == 1) ? 5 : 0, 0);
        req_valid_i = '0;

        // Global stall during WAIT
        set_req(0, 2'd1, 32'h1234_5678, 32'h1234, 4'd9);
        serve(4, 0, 1);

        // Reset in the middle of a divide aborts it silently
        set_req(0, 2'd1, 32'hFFFF_0000, 32'd3, 4'd10);
        #1;
        for (k = 0; k < 20 && req_ready_o == '0; k++) begin @(negedge clk_i); #1; end
        chk("abort_grant", 128'(req_ready_o), 128'(1));
        @(negedge clk_i);
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        prio = 0;
        c_valid = 1'b0;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk_i);
            #1;
            if (rsp_valid_o !== '0 || div_start_o !== 1'b0) ok = 1'b0;
        end
        chk("no_rsp_after_reset", 128'(ok), 128'(1));

`ifdef DIV_ARB_REUSE_EN
        // Fused DIV+REM pair: the second half comes from the cache
        set_req(0, 2'd0, 32'd1000, 32'd3, 4'd11);
        serve(0, 0, 1);
        set_req(1, 2'd2, 32'd1000, 32'd3, 4'd12);
        serve(0, 0, 1);
`endif

        // Randomized traffic
        last_a = 32'd0;
        last_b = 32'd1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                f_op[i] = 2'($urandom_range(0, 3));
                f_tag[i] = TW'($urandom);
                case ($urandom_range(0, 5))
                    0: begin f_a[i] = $urandom_range(0, 7); f_b[i] = $urandom_range(1, 5); end
                    1: begin f_a[i] = $urandom; f_b[i] = $urandom >> $urandom_range(0, 31); end
                    2: begin f_a[i] = $urandom; f_b[i] = 32'd0; end
                    3: begin f_a[i] = 32'h8000_0000; f_b[i] = 32'hFFFF_FFFF; end
                    4: begin f_a[i] = $urandom >> $urandom_range(0, 31); f_b[i] = $urandom_range(1, 100); end
                    default: begin f_a[i] = -32'($urandom_range(1, 1000)); f_b[i] = -32'($urandom_range(1, 9)); end
                endcase
                if ($urandom_range(0, 3) == 0) begin f_a[i] = last_a; f_b[i] = last_b; end
            end
            req_valid_i = N'($urandom_range(1, (1 << N) - 1));
            k = model_pick(req_valid_i);
            if (k >= 0) begin last_a = f_a[k]; last_b = f_b[k]; end
            serve(0, $urandom_range(0, 2), 1);
        end
        req_valid_i = '0;
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
